// File: rtl/bicubic_out_serializer.sv
// Bicubic output serializer: buffers up to two 4x4 pixel blocks from the
// upsampler and emits each block as four row beats (row 0..3) downstream.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both high. Producers hold
// their payload stable while valid is high and the transfer has not happened.
// Upstream: bcci_rsp_valid / os_rsp_ready. Downstream: os_req_valid / dn_rsp_ready.
module bicubic_out_serializer #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int BLK_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bcci_rsp_valid,
  output logic                       os_rsp_ready,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data1,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data2,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data3,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data4,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data5,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data6,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data7,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data8,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data9,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data10,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data11,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data12,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data13,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data14,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data15,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data16,
  output logic                       os_req_valid,
  output logic [4*CHANNEL_WIDTH-1:0] os_data,
  output logic [1:0]                 os_row,
  output logic                       os_last,
  input  logic                       dn_rsp_ready,
  output logic [BLK_CNT_WIDTH-1:0]   blk_cnt
);

  logic [CHANNEL_WIDTH-1:0] in_pix  [16];
  logic [CHANNEL_WIDTH-1:0] buf_mem [2][16];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               count;
  logic [1:0]               row;
  logic                     in_hs;
  logic                     out_hs;
  logic                     last_hs;
  logic [3:0]               pix_idx;

  assign in_pix[0]  = bcci_rsp_data1;
  assign in_pix[1]  = bcci_rsp_data2;
  assign in_pix[2]  = bcci_rsp_data3;
  assign in_pix[3]  = bcci_rsp_data4;
  assign in_pix[4]  = bcci_rsp_data5;
  assign in_pix[5]  = bcci_rsp_data6;
  assign in_pix[6]  = bcci_rsp_data7;
  assign in_pix[7]  = bcci_rsp_data8;
  assign in_pix[8]  = bcci_rsp_data9;
  assign in_pix[9]  = bcci_rsp_data10;
  assign in_pix[10] = bcci_rsp_data11;
  assign in_pix[11] = bcci_rsp_data12;
  assign in_pix[12] = bcci_rsp_data13;
  assign in_pix[13] = bcci_rsp_data14;
  assign in_pix[14] = bcci_rsp_data15;
  assign in_pix[15] = bcci_rsp_data16;

  // Ready depends only on occupancy, never on downstream ready, so a freed
  // entry is offered upstream one cycle after the row-3 beat leaves.
  assign os_rsp_ready = !rst && (count != 2'd2);
  assign os_req_valid = (count != 2'd0);
  assign in_hs        = bcci_rsp_valid && os_rsp_ready;
  assign out_hs       = os_req_valid && dn_rsp_ready;
  assign last_hs      = out_hs && (row == 2'd3);
  assign os_row       = row;
  assign os_last      = (row == 2'd3);

  // Block storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      for (int i = 0; i < 16; i++) begin
        buf_mem[wr_ptr][i] <= in_pix[i];
      end
    end
  end

  // Pointers, occupancy, row index and accepted-block counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      row     <= 2'd0;
      blk_cnt <= '0;
    end else begin
      if (in_hs) begin
        wr_ptr  <= !wr_ptr;
        blk_cnt <= blk_cnt + 1'b1;
      end
      if (out_hs) begin
        row <= row + 2'd1;
      end
      if (last_hs) begin
        rd_ptr <= !rd_ptr;
      end
      case ({in_hs, last_hs})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Row mux from the read entry; forced to zero while nothing is buffered
  // so stale buffer contents never reach the output.
  always_comb begin
    os_data = '0;
    pix_idx = '0;
    if (os_req_valid) begin
      for (int k = 0; k < 4; k++) begin
        pix_idx = {row, k[1:0]};
        os_data[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] = buf_mem[rd_ptr][pix_idx];
      end
    end
  end

endmodule

// File: tb/tb_bicubic_out_serializer.sv
module tb_bicubic_out_serializer;

  logic        clk;
  logic        rst;
  logic        bcci_rsp_valid;
  logic        os_rsp_ready;
  logic [7:0]  pix [16];
  logic        os_req_valid;
  logic [31:0] os_data;
  logic [1:0]  os_row;
  logic        os_last;
  logic        dn_rsp_ready;
  logic [15:0] blk_cnt;

  int total = 0;
  int bad   = 0;

  // Scoreboard: every accepted block contributes four expected row beats.
  logic [31:0] exp_q[$];
  logic [15:0] exp_blk;
  int          m_blocks;
  int          m_row;
  logic [31:0] m_data;

  bicubic_out_serializer #(.CHANNEL_WIDTH(8), .BLK_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .bcci_rsp_valid(bcci_rsp_valid), .os_rsp_ready(os_rsp_ready),
    .bcci_rsp_data1(pix[0]),   .bcci_rsp_data2(pix[1]),
    .bcci_rsp_data3(pix[2]),   .bcci_rsp_data4(pix[3]),
    .bcci_rsp_data5(pix[4]),   .bcci_rsp_data6(pix[5]),
    .bcci_rsp_data7(pix[6]),   .bcci_rsp_data8(pix[7]),
    .bcci_rsp_data9(pix[8]),   .bcci_rsp_data10(pix[9]),
    .bcci_rsp_data11(pix[10]), .bcci_rsp_data12(pix[11]),
    .bcci_rsp_data13(pix[12]), .bcci_rsp_data14(pix[13]),
    .bcci_rsp_data15(pix[14]), .bcci_rsp_data16(pix[15]),
    .os_req_valid(os_req_valid), .os_data(os_data), .os_row(os_row),
    .os_last(os_last), .dn_rsp_ready(dn_rsp_ready), .blk_cnt(blk_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, sampled on the falling edge. Occupancy is the number of
  // blocks with at least one beat still pending; the current row is how many
  // beats of the head block have already left.
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (os_req_valid !== 1'b0 || os_rsp_ready !== 1'b0 || os_data !== 32'h0 ||
          os_row !== 2'd0 || os_last !== 1'b0 || blk_cnt !== 16'h0) begin
        bad++;
        $display("FAIL sb_reset_outputs: valid=%b ready=%b data=%h row=%0d last=%b cnt=%0d, required all zero",
                 os_req_valid, os_rsp_ready, os_data, os_row, os_last, blk_cnt);
      end
      exp_q.delete();
      exp_blk = 16'h0;
    end else begin
      m_blocks = (exp_q.size() + 3) / 4;
      m_row    = (4 - (exp_q.size() % 4)) % 4;
      m_data   = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
      total++;
      if (os_rsp_ready !== (m_blocks != 2)) begin
        bad++;
        $display("FAIL sb_ready: got %b required %b", os_rsp_ready, (m_blocks != 2));
      end
      total++;
      if (os_req_valid !== (exp_q.size() != 0)) begin
        bad++;
        $display("FAIL sb_valid: got %b required %b", os_req_valid, (exp_q.size() != 0));
      end
      total++;
      if (os_row !== 2'(m_row) || os_last !== (m_row == 3)) begin
        bad++;
        $display("FAIL sb_row: got row=%0d last=%b required row=%0d last=%b",
                 os_row, os_last, m_row, (m_row == 3));
      end
      total++;
      if (os_data !== m_data) begin
        bad++;
        $display("FAIL sb_data: got %h required %h", os_data, m_data);
      end
      total++;
      if (blk_cnt !== exp_blk) begin
        bad++;
        $display("FAIL sb_blk_cnt: got %0d required %0d", blk_cnt, exp_blk);
      end
      // Transfers that the coming rising edge will perform.
      if (exp_q.size() != 0 && dn_rsp_ready) void'(exp_q.pop_front());
      if (bcci_rsp_valid && m_blocks != 2) begin
        for (int r = 0; r < 4; r++)
          exp_q.push_back({pix[4*r+3], pix[4*r+2], pix[4*r+1], pix[4*r]});
        exp_blk = exp_blk + 16'h1;
      end
    end
  end

  // Driver: fresh random pixels.
  task automatic rand_pix();
    for (int i = 0; i < 16; i++) pix[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic drain();
    @(posedge clk); #1;
    bcci_rsp_valid = 1'b0;
    dn_rsp_ready   = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (os_req_valid !== 1'b0 || os_rsp_ready !== 1'b0 || os_data !== 32'h0 ||
        os_row !== 2'd0 || os_last !== 1'b0 || blk_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b ready=%b data=%h row=%0d last=%b cnt=%0d, required all zero",
               os_req_valid, os_rsp_ready, os_data, os_row, os_last, blk_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] want;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) pix[i] = 8'(i + 1);
    bcci_rsp_valid = 1'b1;
    dn_rsp_ready   = 1'b1;
    @(negedge clk);
    total++;
    if (os_rsp_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_accept: ready=%b required 1", os_rsp_ready);
    end
    @(posedge clk); #1;
    bcci_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      want = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
      total++;
      if (os_req_valid !== 1'b1 || os_data !== want || os_last !== (i == 3)) begin
        bad++;
        $display("FAIL single_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                 i, os_req_valid, os_data, os_last, want, (i == 3));
      end
    end
    @(negedge clk);
    total++;
    if (blk_cnt !== 16'd1 || os_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_end: cnt=%0d valid=%b required 1 0", blk_cnt, os_req_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] saved;
    int accepts;
    logic acc_now;
    accepts = 0;
    @(posedge clk); #1;
    dn_rsp_ready = 1'b0;
    rand_pix();
    saved = {pix[3], pix[2], pix[1], pix[0]};
    bcci_rsp_valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      acc_now = os_rsp_ready;
      if (acc_now) accepts++;
      @(posedge clk); #1;
      if (acc_now) rand_pix();
    end
    @(negedge clk);
    total++;
    if (accepts != 2 || os_rsp_ready !== 1'b0 || os_data !== saved || os_row !== 2'd0) begin
      bad++;
      $display("FAIL backpressure: accepts=%0d ready=%b data=%h row=%0d required 2 0 %h 0",
               accepts, os_rsp_ready, os_data, os_row, saved);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    logic pending;
    int guard;
    int checked;
    pending = 1'b0;
    checked = 0;
    guard = 0;
    @(posedge clk); #1;
    dn_rsp_ready   = 1'b0;
    rand_pix();
    bcci_rsp_valid = 1'b1;
    // Fill both entries.
    while (guard < 10) begin
      @(negedge clk);
      guard++;
      if (!os_rsp_ready) break;
      @(posedge clk); #1;
      rand_pix();
    end
    @(posedge clk); #1;
    dn_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (pending) begin
        checked++;
        total++;
        if (os_rsp_ready !== 1'b1) begin
          bad++;
          $display("FAIL simul_reaccept: ready=%b required 1 after row-3 beat", os_rsp_ready);
        end
      end
      pending = os_last && os_req_valid && !os_rsp_ready;
      @(posedge clk); #1;
      if (os_rsp_ready) rand_pix();
    end
    total++;
    if (checked == 0) begin
      bad++;
      $display("FAIL simul_seen: row-3 beats at full occupancy=%0d required >0", checked);
    end
    drain();
  endtask

  task automatic test_stream();
    int found;
    fork
      begin
        int acc;
        int guard;
        logic hit;
        acc = 0;
        guard = 0;
        @(posedge clk); #1;
        rand_pix();
        bcci_rsp_valid = 1'b1;
        while (acc < 8 && guard < 200) begin
          @(negedge clk);
          guard++;
          hit = os_rsp_ready;
          if (hit) acc++;
          @(posedge clk); #1;
          if (acc >= 8) bcci_rsp_valid = 1'b0;
          else if (hit) rand_pix();
        end
        bcci_rsp_valid = 1'b0;
      end
      begin
        found = 0;
        for (int g = 0; g < 20 && found == 0; g++) begin
          @(negedge clk);
          if (os_req_valid) found = 1;
        end
        total++;
        if (found == 0) begin
          bad++;
          $display("FAIL stream_start: no beat within 20 cycles");
        end else begin
          for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (os_req_valid !== 1'b1 || os_row !== 2'(i % 4)) begin
              bad++;
              $display("FAIL stream_beat%0d: valid=%b row=%0d required 1 %0d",
                       i, os_req_valid, os_row, i % 4);
            end
          end
        end
      end
    join
    drain();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      bcci_rsp_valid = 1'($urandom_range(0, 1));
      dn_rsp_ready   = 1'($urandom_range(0, 3) != 0);
      rand_pix();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] saved;
    int found;
    found = 0;
    @(posedge clk); #1;
    dn_rsp_ready = 1'b1;
    rand_pix();
    bcci_rsp_valid = 1'b1;
    @(posedge clk); #1;
    bcci_rsp_valid = 1'b0;
    for (int g = 0; g < 10 && found == 0; g++) begin
      @(negedge clk);
      if (os_req_valid && os_row == 2'd1) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL rstmid_row1: row-1 beat not seen");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if (os_req_valid !== 1'b0 || os_rsp_ready !== 1'b0 || os_data !== 32'h0 ||
        os_row !== 2'd0 || os_last !== 1'b0 || blk_cnt !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_async: valid=%b ready=%b data=%h row=%0d last=%b cnt=%0d, required all zero",
               os_req_valid, os_rsp_ready, os_data, os_row, os_last, blk_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rand_pix();
    saved = {pix[3], pix[2], pix[1], pix[0]};
    bcci_rsp_valid = 1'b1;
    @(posedge clk); #1;
    bcci_rsp_valid = 1'b0;
    @(negedge clk);
    total++;
    if (os_req_valid !== 1'b1 || os_row !== 2'd0 || os_data !== saved || blk_cnt !== 16'd1) begin
      bad++;
      $display("FAIL rstmid_fresh: valid=%b row=%0d data=%h cnt=%0d required 1 0 %h 1",
               os_req_valid, os_row, os_data, blk_cnt, saved);
    end
    drain();
  endtask

  initial begin
    rst            = 1'b1;
    bcci_rsp_valid = 1'b0;
    dn_rsp_ready   = 1'b1;
    for (int i = 0; i < 16; i++) pix[i] = 8'h0;
    test_reset();
    test_single();
    test_backpressure();
    test_simultaneous();
    test_stream();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
